axi4_lite_slave: RTL and testbench
==================================

Name: axi4_lite_slave

Overview:
AXI4-Lite subordinate (responder) with a bank of NUM_REGS 32-bit read/write registers. It pairs with the axi4_lite_master block. It accepts write address and write data independently, in any order or together, and commits byte-strobed writes. It serves single-beat reads with one-cycle latency. Write and read channels run concurrent, independent FSMs.

Parameters:
ADDR_WIDTH, 32, width of awaddr_in and araddr_in.
DATA_WIDTH, 32, data width. Only 32 is supported.
NUM_REGS, 16, number of 32-bit registers. Must be a power of 2, at least 2. Register i sits at byte address 4*i.

Ports:
aclk  in  1  clock; all state changes on rising edge.
areset  in  1  asynchronous, active-high reset.
awaddr_in  in  ADDR_WIDTH  write address.
awprot_in  in  3  accepted and ignored.
awvalid_in  in  1  write address valid.
awready_out  out  1  write address ready.
wdata_in  in  32  write data.
wstrb_in  in  4  byte strobes; bit k enables byte k.
wvalid_in  in  1  write data valid.
wready_out  out  1  write data ready.
bresp_out  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
bvalid_out  out  1  write response valid.
bready_in  in  1  write response ready.
araddr_in  in  ADDR_WIDTH  read address.
arprot_in  in  3  accepted and ignored.
arvalid_in  in  1  read address valid.
arready_out  out  1  read address ready.
rdata_out  out  32  read data.
rresp_out  out  2  read response.
rvalid_out  out  1  read data valid.
rready_in  in  1  read data ready.

Behaviour:
- Reset (async, areset=1): all registers = 0. All ready and valid outputs = 0. bresp_out, rresp_out and rdata_out = 0. In-flight transactions are dropped with no response. On the first rising edge with areset=0, awready_out, wready_out and arready_out go to 1.
- All outputs are registered. A handshake completes on a rising edge where valid && ready.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE, both AW and W handshake on the same edge -> W_RESP.
  - W_IDLE, AW only -> W_HAVE_ADDR; awready_out=0.
  - W_IDLE, W only -> W_HAVE_DATA; wready_out=0.
  - W_HAVE_ADDR, W handshake -> W_RESP.
  - W_HAVE_DATA, AW handshake -> W_RESP.
  - On entry to W_RESP (same edge): register write commits, bvalid_out=1, bresp_out set, awready_out=wready_out=0.
  - W_RESP: bvalid_out and bresp_out held stable until bready_in=1. On the B handshake edge -> W_IDLE: bvalid_out=0, awready_out=wready_out=1.
  - Best-case back-to-back write spacing is 2 cycles. At most one outstanding write.
- Register index = addr[2+log2(NUM_REGS)-1:2]. addr[1:0] is ignored (treated as aligned).
- Byte lane k of the target register is updated only if wstrb_in[k]=1. wstrb=4'b0000 writes nothing but still returns OKAY.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready_out=1. On AR handshake -> R_DATA on the next edge with rvalid_out=1, rdata_out=register value, rresp_out set, arready_out=0. Latency is 1 cycle.
  - R_DATA: rdata_out and rresp_out held stable until rready_in=1. On the R handshake edge -> R_IDLE: rvalid_out=0, arready_out=1.
- Simultaneous write commit and read capture of the same register on the same edge: the read returns the pre-write value.
- Out-of-range address (addr >= 4*NUM_REGS): see optional feature.
- bvalid_out and rvalid_out never drop without the matching ready. No combinational path from any input to any output.

Optional Feature:
Macro AXI4_LITE_SLAVE_DECERR_EN.
- Defined: out-of-range write updates no register and returns bresp_out=2'b10. Out-of-range read returns rdata_out=0 and rresp_out=2'b10.
- Undefined: address upper bits are ignored, so accesses alias modulo 4*NUM_REGS. Responses are always 2'b00.
- In-range behaviour is identical in both builds.

Test Plan:
- Reset then write: awaddr=0x10, wdata=0xF0B4A596, wstrb=4'b1111, AW and W on the same cycle -> bvalid_out=1 on the next edge with bresp=00. Read 0x10 -> rdata=0xF0B4A596 one cycle after the AR handshake, rresp=00.
- Partial strobe and ordering: W (wdata=0xAABBCCDD, wstrb=4'b1011) presented 3 cycles before AW to reg 4 (addr 0x10), with reg 4 previously 0xF0B4A596 -> wready_out=0 while waiting. Read 0x10 -> 0xAAB4CCDD.
- Backpressure: hold bready_in=0 and rready_in=0 for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stay stable; awready, wready and arready stay 0. Release -> valids drop on the handshake edge and readies rise.
- Out-of-range 0x40 with NUM_REGS=16, write 0x12345678 then read -> with macro: bresp=10, rresp=10, rdata=0, all registers unchanged. Without macro: aliases reg 0; read 0x00 returns 0x12345678 with OKAY.
- Concurrent access: write 0x55 to 0x08 while a read of 0x08 is captured on the commit edge -> read returns the old value; a following read returns 0x55.
- Reset mid-operation: assert areset while in W_RESP and R_DATA -> bvalid_out and rvalid_out drop immediately (asynchronously) and all registers read 0 after release.

Source files
------------

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite responder with NUM_REGS byte-strobed 32-bit registers; independent write and read FSMs.
// Optional build macro AXI4_LITE_SLAVE_DECERR_EN: out-of-range accesses get SLVERR instead of aliasing.
module axi4_lite_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ADDR_WIDTH-1:0]   awaddr_in,
   input  logic [2:0]              awprot_in,
   input  logic                    awvalid_in,
   output logic                    awready_out,
   input  logic [DATA_WIDTH-1:0]   wdata_in,
   input  logic [DATA_WIDTH/8-1:0] wstrb_in,
   input  logic                    wvalid_in,
   output logic                    wready_out,
   output logic [1:0]              bresp_out,
   output logic                    bvalid_out,
   input  logic                    bready_in,
   input  logic [ADDR_WIDTH-1:0]   araddr_in,
   input  logic [2:0]              arprot_in,
   input  logic                    arvalid_in,
   output logic                    arready_out,
   output logic [DATA_WIDTH-1:0]   rdata_out,
   output logic [1:0]              rresp_out,
   output logic                    rvalid_out,
   input  logic                    rready_in
);

   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic                  awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d, arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = awvalid_in & awready_q;
   assign w_hs  = wvalid_in  & wready_q;
   assign b_hs  = bvalid_q   & bready_in;
   assign ar_hs = arvalid_in & arready_q;
   assign r_hs  = rvalid_q   & rready_in;

   // Address/data may arrive on this edge or have been parked earlier.
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [DATA_WIDTH-1:0] eff_data;
   logic [STRB_W-1:0]     eff_strb;
   logic [IDX_W-1:0]      w_idx, r_idx;
   logic                  w_oor, r_oor, commit;

   assign eff_addr = aw_hs ? awaddr_in : awaddr_q;
   assign eff_data = w_hs  ? wdata_in  : wdata_q;
   assign eff_strb = w_hs  ? wstrb_in  : wstrb_q;
   assign w_idx    = eff_addr[2+IDX_W-1:2];
   assign r_idx    = araddr_in[2+IDX_W-1:2];

`ifdef AXI4_LITE_SLAVE_DECERR_EN
   assign w_oor = |eff_addr[ADDR_WIDTH-1:2+IDX_W];
   assign r_oor = |araddr_in[ADDR_WIDTH-1:2+IDX_W];
`else
   assign w_oor = 1'b0;
   assign r_oor = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{awprot_in, arprot_in, awaddr_in, araddr_in, awaddr_q};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) w_state_d = W_RESP;
            else if (aw_hs)    w_state_d = W_HAVE_ADDR;
            else if (w_hs)     w_state_d = W_HAVE_DATA;
         end
         W_HAVE_ADDR: if (w_hs)  w_state_d = W_RESP;
         W_HAVE_DATA: if (aw_hs) w_state_d = W_RESP;
         W_RESP:      if (b_hs)  w_state_d = W_IDLE;
         default:     w_state_d = W_IDLE;
      endcase

      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (r_hs)  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   assign commit = (w_state_q != W_RESP) && (w_state_d == W_RESP);

   // Readies follow the next state, so they rise on the first edge after reset release.
   always_comb begin
      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
      bvalid_d  = (w_state_d == W_RESP);
      bresp_d   = bresp_q;
      if (commit) bresp_d = w_oor ? RESP_SLVERR : RESP_OKAY;
      awaddr_d  = aw_hs ? awaddr_in : awaddr_q;
      wdata_d   = w_hs  ? wdata_in  : wdata_q;
      wstrb_d   = w_hs  ? wstrb_in  : wstrb_q;

      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (ar_hs) begin
         rdata_d = r_oor ? '0 : regs_q[r_idx];
         rresp_d = r_oor ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // Read capture uses regs_q, so a same-edge commit is not visible to that read.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
      if (commit && !w_oor) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (eff_strb[k]) regs_d[w_idx][8*k +: 8] = eff_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign awready_out = awready_q;
   assign wready_out  = wready_q;
   assign bvalid_out  = bvalid_q;
   assign bresp_out   = bresp_q;
   assign arready_out = arready_q;
   assign rvalid_out  = rvalid_q;
   assign rdata_out   = rdata_q;
   assign rresp_out   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: reset, strobes, ordering, backpressure, aliasing/DECERR, async reset.
// Inputs change 1 ns after a rising edge; outputs are sampled there or on the falling edge.
module tb_axi4_lite_slave;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   axi4_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr_in(awaddr), .awprot_in(awprot), .awvalid_in(awvalid), .awready_out(awready),
      .wdata_in(wdata), .wstrb_in(wstrb), .wvalid_in(wvalid), .wready_out(wready),
      .bresp_out(bresp), .bvalid_out(bvalid), .bready_in(bready),
      .araddr_in(araddr), .arprot_in(arprot), .arvalid_in(arvalid), .arready_out(arready),
      .rdata_out(rdata), .rresp_out(rresp), .rvalid_out(rvalid), .rready_in(rready)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      logic aw_done, w_done, hs_aw, hs_w, got_b;
      int cnt;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; cnt = 0;
      while (!(aw_done && w_done) && cnt < 20) begin
         @(negedge aclk);
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         tick();
         if (hs_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
         if (hs_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
         cnt++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_accepted", 32'(aw_done && w_done), 32'd1);
      check("wr_bvalid_latency", 32'(bvalid), 32'd1);
      resp = 2'b11; got_b = 1'b0; cnt = 0; bready = 1'b1;
      while (!got_b && cnt < 20) begin
         @(negedge aclk);
         if (bvalid) begin got_b = 1'b1; resp = bresp; end
         tick();
         cnt++;
      end
      bready = 1'b0;
      check("wr_b_handshake", 32'(got_b), 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic ar_done, hs_ar, got_r;
      int cnt;
      araddr = addr; arvalid = 1'b1; ar_done = 1'b0; cnt = 0;
      while (!ar_done && cnt < 20) begin
         @(negedge aclk);
         hs_ar = arvalid && arready;
         tick();
         if (hs_ar) begin ar_done = 1'b1; arvalid = 1'b0; end
         cnt++;
      end
      arvalid = 1'b0;
      check("rd_accepted", 32'(ar_done), 32'd1);
      check("rd_rvalid_latency", 32'(rvalid), 32'd1);
      data = 32'hDEAD_BEEF; resp = 2'b11; got_r = 1'b0; cnt = 0; rready = 1'b1;
      while (!got_r && cnt < 20) begin
         @(negedge aclk);
         if (rvalid) begin got_r = 1'b1; data = rdata; resp = rresp; end
         tick();
         cnt++;
      end
      rready = 1'b0;
      check("rd_r_handshake", 32'(got_r), 32'd1);
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
      logic [31:0] d;
      logic [1:0]  r;
      exp_q.push_back(exp_data);
      axi_read(addr, d, r);
      check({tag, "_data"}, d, exp_q.pop_front());
      check({tag, "_resp"}, 32'(r), 32'(exp_resp));
   endtask

   task automatic check_readies(input string tag, input logic exp);
      check({tag, "_awready"}, 32'(awready), 32'(exp));
      check({tag, "_wready"},  32'(wready),  32'(exp));
      check({tag, "_arready"}, 32'(arready), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] resp;
      areset = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

      #12;
      check_readies("reset", 1'b0);
      check("reset_bvalid", 32'(bvalid), 32'd0);
      check("reset_rvalid", 32'(rvalid), 32'd0);
      check("reset_bresp",  32'(bresp),  32'd0);
      check("reset_rresp",  32'(rresp),  32'd0);
      check("reset_rdata",  rdata,       32'd0);
      tick();
      areset = 1'b0;
      tick();
      check_readies("post_reset", 1'b1);

      // Full-word write with AW and W together, then read back.
      axi_write(32'h10, 32'hF0B4_A596, 4'b1111, resp);
      check("t1_bresp", 32'(resp), 32'd0);
      read_check("t1_rd", 32'h10, 32'hF0B4_A596, 2'b00);

      // W arrives three cycles ahead of AW with a partial strobe.
      wdata = 32'hAABB_CCDD; wstrb = 4'b1011; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_wready_wait", 32'(wready), 32'd0);
         check("t2_awready_wait", 32'(awready), 32'd1);
         check("t2_bvalid_wait", 32'(bvalid), 32'd0);
         tick();
      end
      awaddr = 32'h10; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("t2_bvalid", 32'(bvalid), 32'd1);
      check("t2_bresp", 32'(bresp), 32'd0);
      check("t2_awready_resp", 32'(awready), 32'd0);
      check("t2_wready_resp", 32'(wready), 32'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("t2_bvalid_drop", 32'(bvalid), 32'd0);
      check("t2_awready_back", 32'(awready), 32'd1);
      check("t2_wready_back", 32'(wready), 32'd1);
      read_check("t2_rd", 32'h10, 32'hAAB4_CCDD, 2'b00);

      // Zero strobe: OKAY, nothing written.
      axi_write(32'h10, 32'hFFFF_FFFF, 4'b0000, resp);
      check("t3_bresp", 32'(resp), 32'd0);
      read_check("t3_rd", 32'h10, 32'hAAB4_CCDD, 2'b00);

      // Backpressure on both response channels.
      awaddr = 32'h0C; wdata = 32'hCAFE_BABE; wstrb = 4'b1111; araddr = 32'h10;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", 32'(bvalid), 32'd1);
         check("bp_rvalid", 32'(rvalid), 32'd1);
         check("bp_bresp",  32'(bresp),  32'd0);
         check("bp_rresp",  32'(rresp),  32'd0);
         check("bp_rdata",  rdata,       32'hAAB4_CCDD);
         check_readies("bp", 1'b0);
         tick();
      end
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      check("bp_bvalid_drop", 32'(bvalid), 32'd0);
      check("bp_rvalid_drop", 32'(rvalid), 32'd0);
      check_readies("bp_release", 1'b1);
      read_check("bp_rd", 32'h0C, 32'hCAFE_BABE, 2'b00);

      // Read captured on the same edge as a write commit to the same register.
      axi_write(32'h08, 32'h1111_2222, 4'b1111, resp);
      awaddr = 32'h08; wdata = 32'h0000_0055; wstrb = 4'b1111; araddr = 32'h08;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("cc_rvalid", 32'(rvalid), 32'd1);
      check("cc_old_data", rdata, 32'h1111_2222);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      read_check("cc_new", 32'h08, 32'h0000_0055, 2'b00);

      // Out-of-range address 0x40.
      axi_write(32'h40, 32'h1234_5678, 4'b1111, resp);
`ifdef AXI4_LITE_SLAVE_DECERR_EN
      check("oor_bresp", 32'(resp), 32'd2);
      read_check("oor_rd", 32'h40, 32'h0, 2'b10);
      read_check("oor_reg0", 32'h00, 32'h0, 2'b00);
`else
      check("oor_bresp", 32'(resp), 32'd0);
      read_check("oor_rd", 32'h40, 32'h1234_5678, 2'b00);
      read_check("oor_reg0", 32'h00, 32'h1234_5678, 2'b00);
`endif
      read_check("oor_reg2", 32'h08, 32'h0000_0055, 2'b00);

      // Reset while in W_RESP and R_DATA.
      awaddr = 32'h04; wdata = 32'hDEAD_0001; wstrb = 4'b1111; araddr = 32'h0C;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("mr_bvalid", 32'(bvalid), 32'd1);
      check("mr_rvalid", 32'(rvalid), 32'd1);
      #2 areset = 1'b1;
      #1;
      check("mr_bvalid_async", 32'(bvalid), 32'd0);
      check("mr_rvalid_async", 32'(rvalid), 32'd0);
      check("mr_rdata_async",  rdata,       32'd0);
      tick();
      check_readies("mr_in_reset", 1'b0);
      areset = 1'b0;
      tick();
      check_readies("mr_release", 1'b1);
      read_check("mr_reg4", 32'h10, 32'h0, 2'b00);
      read_check("mr_reg3", 32'h0C, 32'h0, 2'b00);
      read_check("mr_reg2", 32'h08, 32'h0, 2'b00);
      read_check("mr_reg1", 32'h04, 32'h0, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
